// File: rtl/multi_done_watchdog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_done_watchdog_pkg : channel state encoding and parameter limits
// Rev 1.0
// ---------------------------------------------------------------------------
package multi_done_watchdog_pkg;

  localparam int NUM_CH_MIN    = 1;
  localparam int NUM_CH_MAX    = 32;
  localparam int TIMEOUT_W_MIN = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/done_watchdog_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// done_watchdog_ch : one completion channel (FSM, cycle counter, budget latch)
// Rev 1.0
// ---------------------------------------------------------------------------
module done_watchdog_ch
  import multi_done_watchdog_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 done,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  output logic                 busy,
  output logic                 done_sticky,
  output logic                 timeout,
  output logic                 done_pulse
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  ch_state_e            state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] budget_q, budget_d;
  logic                 pulse_q, pulse_d;
  logic                 expire;

  // Expiry is one count early so the flag rises exactly budget cycles after arming.
  assign expire = (budget_q != '0) && (cnt_q == budget_q - CNT_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    budget_d = budget_q;
    pulse_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          budget_d = timeout_cfg;
        end
      end
      ST_RUN: begin
        if (done) begin
          state_d = ST_DONE;
          pulse_d = 1'b1;
        end else if (start) begin
          cnt_d    = '0;
          budget_d = timeout_cfg;
        end else if (expire) begin
          state_d = ST_TIMEOUT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (clear) begin
          if (start) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            budget_d = timeout_cfg;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      budget_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      budget_q <= budget_d;
      pulse_q  <= pulse_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done_sticky = (state_q == ST_DONE);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign done_pulse  = pulse_q;

endmodule
`default_nettype wire

// File: rtl/multi_done_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_done_watchdog : NUM_CH independent completion watchdogs plus summaries
// Rev 1.0
// ---------------------------------------------------------------------------
module multi_done_watchdog
  import multi_done_watchdog_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    start,
  input  logic [NUM_CH-1:0]    done,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    done_sticky,
  output logic [NUM_CH-1:0]    timeout,
  output logic [NUM_CH-1:0]    done_pulse,
  output logic                 all_done,
  output logic                 any_timeout
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || TIMEOUT_W < TIMEOUT_W_MIN) begin : g_bad_param
    $error("multi_done_watchdog: parameter out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    done_watchdog_ch #(
      .TIMEOUT_W (TIMEOUT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .start       (start[i]),
      .done        (done[i]),
      .clear       (clear),
      .timeout_cfg (timeout_cfg),
      .busy        (busy[i]),
      .done_sticky (done_sticky[i]),
      .timeout     (timeout[i]),
      .done_pulse  (done_pulse[i])
    );
  end

  assign all_done    = &done_sticky;
  assign any_timeout = |timeout;

endmodule
`default_nettype wire

// File: tb/tb_multi_done_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multi_done_watchdog : directed self-checking bench, NUM_CH=2 TIMEOUT_W=8
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multi_done_watchdog;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] done  = '0;
  logic       clear = 1'b0;
  logic [7:0] timeout_cfg = '0;
  logic [1:0] busy, done_sticky, timeout, done_pulse;
  logic       all_done, any_timeout;

  int checks = 0;
  int errors = 0;

  multi_done_watchdog #(
    .NUM_CH    (2),
    .TIMEOUT_W (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .clear       (clear),
    .timeout_cfg (timeout_cfg),
    .busy        (busy),
    .done_sticky (done_sticky),
    .timeout     (timeout),
    .done_pulse  (done_pulse),
    .all_done    (all_done),
    .any_timeout (any_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {22'd0, busy, done_sticky, timeout, done_pulse, all_done, any_timeout}, 32'd0);
  endtask

  initial begin
    logic bad;

    #1 reset = 1'b1;
    #2 check_all_zero("reset_outputs");
    @(negedge clock);
    reset = 1'b0;

    // Done after four edges
    timeout_cfg = 8'd10;
    start = 2'b01;
    step();
    start = 2'b00;
    check("r31_busy_e0", busy, 2'b01);
    step(); step(); step();
    check("r31_busy_e3", busy, 2'b01);
    check("r31_no_pulse_yet", done_pulse, 2'b00);
    done = 2'b01;
    step();
    done = 2'b00;
    check("r31_pulse", done_pulse, 2'b01);
    check("r31_sticky", done_sticky, 2'b01);
    check("r31_busy_off", busy, 2'b00);
    step();
    check("r31_pulse_one_cycle", done_pulse, 2'b00);
    start = 2'b01;
    step(); step();
    start = 2'b00;
    check("r31_start_ignored", {busy, done_sticky}, {2'b00, 2'b01});
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("r31_clear", done_sticky, 2'b00);

    // Timeout on ch1; cfg changed mid-run must not matter
    timeout_cfg = 8'd10;
    start = 2'b10;
    step();
    start = 2'b00;
    timeout_cfg = 8'd3;
    for (int i = 1; i <= 9; i++) step();
    check("r32_before_to", {timeout, busy}, {2'b00, 2'b10});
    step();
    check("r32_timeout", timeout, 2'b10);
    check("r32_any_timeout", any_timeout, 1'b1);
    check("r32_busy_off", busy, 2'b00);
    step(); step(); step();
    check("r32_held", {timeout, any_timeout}, {2'b10, 1'b1});
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("r32_clear", {timeout, any_timeout}, 3'b000);

    // Done on the same edge as the timeout condition
    timeout_cfg = 8'd3;
    start = 2'b01;
    step();
    start = 2'b00;
    step(); step();
    done = 2'b01;
    step();
    done = 2'b00;
    check("r33_done_wins", {done_sticky, timeout, done_pulse}, {2'b01, 2'b00, 2'b01});
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Budget 0: never times out, counter saturates
    timeout_cfg = 8'd0;
    start = 2'b01;
    step();
    start = 2'b00;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (busy[0] !== 1'b1 || timeout[0] !== 1'b0) bad = 1'b1;
    end
    check("r34_no_timeout", bad, 1'b0);
    done = 2'b01;
    step();
    done = 2'b00;
    check("r34_done", done_sticky, 2'b01);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Both channels, all_done and clear+start
    timeout_cfg = 8'd20;
    start = 2'b11;
    step();
    start = 2'b00;
    check("r35_both_busy", busy, 2'b11);
    step();
    done = 2'b01;
    step();
    done = 2'b00;
    check("r35_one_done", {done_sticky, all_done}, {2'b01, 1'b0});
    step(); step();
    done = 2'b10;
    step();
    done = 2'b00;
    check("r35_all_done", {done_sticky, all_done, done_pulse}, {2'b11, 1'b1, 2'b10});
    timeout_cfg = 8'd5;
    clear = 1'b1;
    start = 2'b01;
    step();
    clear = 1'b0;
    start = 2'b00;
    check("r35_clear_start", {busy, done_sticky, all_done}, {2'b01, 2'b00, 1'b0});

    // Asynchronous reset mid-run on ch0 (budget 5)
    step(); step();
    #2 reset = 1'b1;
    #1 check_all_zero("r36_async_reset");
    @(negedge clock);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_pulse !== 2'b00 || timeout !== 2'b00 || busy !== 2'b00) bad = 1'b1;
    end
    check("r36_quiet_after", bad, 1'b0);
    start = 2'b01;
    step();
    start = 2'b00;
    check("r36_restart", busy, 2'b01);
    for (int i = 1; i <= 5; i++) step();
    check("r36_new_timeout", timeout, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
